// File: rtl/sp_ram_be.sv
// Single-port RAM with per-byte write enables, selectable read-during-write
// behaviour and a fixed-latency read pipeline that flags each new result.
module sp_ram_be #(
  parameter int    WIDTH      = 32,
  parameter int    DEPTH      = 1024,
  parameter int    BYTE_W     = 8,
  parameter int    LATENCY    = 1,
  parameter string WRITE_MODE = "READ_FIRST",
  parameter string INIT_FILE  = ""
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       we,
  input  logic [WIDTH/BYTE_W-1:0]    be,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid
);

  localparam int NB = WIDTH / BYTE_W;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam bit IS_WF = (WRITE_MODE == "WRITE_FIRST");
  localparam bit IS_NC = (WRITE_MODE == "NO_CHANGE");

  logic [WIDTH-1:0] mem [DEPTH];

  logic             in_range;
  logic             wr_en;
  logic             rd_valid;
  logic [WIDTH-1:0] old_word;
  logic [WIDTH-1:0] merged_word;
  logic [WIDTH-1:0] rd_word;

  logic [WIDTH-1:0]   pipe_data [LATENCY];
  logic [LATENCY-1:0] pipe_valid;

  // Power-up contents only; reset never touches the array.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  assign in_range = ({1'b0, addr} < DEPTH_W);
  assign wr_en    = en && we && in_range;
  assign rd_valid = en && !(we && IS_NC);

  always_comb begin
    old_word    = in_range ? mem[addr] : '0;
    merged_word = old_word;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) merged_word[i*BYTE_W +: BYTE_W] = din[i*BYTE_W +: BYTE_W];
    end
  end

  // Out-of-range accesses always yield zero, whatever the write mode.
  assign rd_word = !in_range     ? '0 :
                   (we && IS_WF) ? merged_word : old_word;

  // Writes are suppressed while reset is held; the array itself is never cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n && wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[addr][i*BYTE_W +: BYTE_W] <= din[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= '0;
      for (int s = 0; s < LATENCY; s++) pipe_data[s] <= '0;
    end else begin
      pipe_valid[0] <= rd_valid;
      if (rd_valid) pipe_data[0] <= rd_word;
      for (int s = 1; s < LATENCY; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        if (pipe_valid[s-1]) pipe_data[s] <= pipe_data[s-1];
      end
    end
  end

  assign dout       = pipe_data[LATENCY-1];
  assign dout_valid = pipe_valid[LATENCY-1];

endmodule

// File: tb/tb_sp_ram_be.sv
// Bench for sp_ram_be: three configurations share one stimulus stream and are
// checked every cycle against a timeline model, plus hand-computed literals.
module tb_sp_ram_be;

  localparam int NI = 3;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        en    = 1'b0;
  logic        we    = 1'b0;
  logic [3:0]  be    = '0;
  logic [3:0]  addr  = '0;
  logic [31:0] din   = '0;

  logic [31:0] dout_rf, dout_wf, dout_nc;
  logic        dv_rf, dv_wf, dv_nc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sp_ram_be #(.WIDTH(32), .DEPTH(16), .BYTE_W(8), .LATENCY(1), .WRITE_MODE("READ_FIRST"))
    u_rf (.clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .addr(addr), .din(din),
          .dout(dout_rf), .dout_valid(dv_rf));

  sp_ram_be #(.WIDTH(32), .DEPTH(16), .BYTE_W(8), .LATENCY(3), .WRITE_MODE("WRITE_FIRST"))
    u_wf (.clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .addr(addr), .din(din),
          .dout(dout_wf), .dout_valid(dv_wf));

  sp_ram_be #(.WIDTH(32), .DEPTH(12), .BYTE_W(8), .LATENCY(4), .WRITE_MODE("NO_CHANGE"))
    u_nc (.clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .addr(addr), .din(din),
          .dout(dout_nc), .dout_valid(dv_nc));

  // Model configuration: mode 0 = read-first, 1 = write-first, 2 = no-change.
  int    lat  [NI] = '{1, 3, 4};
  int    mode [NI] = '{0, 1, 2};
  int    dep  [NI] = '{16, 16, 12};
  string nm   [NI] = '{"rf", "wf", "nc"};

  bit [31:0] mmem  [NI][16];
  bit        res_v [NI][4096];
  bit [31:0] res_d [NI][4096];
  bit        exp_v [NI];
  bit [31:0] exp_d [NI];
  bit [31:0] last_seen [NI];
  int        cyc       = 0;
  int        kill_edge = 0;

  function automatic logic [31:0] actData(int k);
    case (k)
      0:       return dout_rf;
      1:       return dout_wf;
      default: return dout_nc;
    endcase
  endfunction

  function automatic logic actValid(int k);
    case (k)
      0:       return dv_rf;
      1:       return dv_wf;
      default: return dv_nc;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic w, input logic [3:0] b,
                               input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    en = e; we = w; be = b; addr = a; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  // Any access at or before the edge preceding a reset is lost.
  always @(negedge rst_n) begin
    kill_edge = cyc;
    for (int k = 0; k < NI; k++) begin
      exp_v[k] = 1'b0;
      exp_d[k] = '0;
    end
  end

  // Each edge: record the result of this access, then deliver the one LATENCY-1 edges old.
  always @(posedge clk) begin : model
    bit        inr;
    bit [31:0] old_w, mrg;
    int        src;
    cyc++;
    for (int k = 0; k < NI; k++) begin
      res_v[k][cyc] = 1'b0;
      if (rst_n && en) begin
        inr   = (int'(addr) < dep[k]);
        old_w = inr ? mmem[k][addr] : 32'h0;
        mrg   = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) mrg[b*8 +: 8] = din[b*8 +: 8];
        if (!we) begin
          res_v[k][cyc] = 1'b1;
          res_d[k][cyc] = old_w;
        end else begin
          if (inr) mmem[k][addr] = mrg;
          if (mode[k] != 2) begin
            res_v[k][cyc] = 1'b1;
            res_d[k][cyc] = (mode[k] == 1 && inr) ? mrg : old_w;
          end
        end
      end
      src = cyc - lat[k] + 1;
      if (src >= 1 && src > kill_edge && res_v[k][src]) begin
        exp_v[k] = 1'b1;
        exp_d[k] = res_d[k][src];
      end else begin
        exp_v[k] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin : compare
    #2;
    for (int k = 0; k < NI; k++) begin
      checkOutput({nm[k], "_valid"}, {31'h0, actValid(k)}, {31'h0, exp_v[k]});
      checkOutput({nm[k], "_dout"}, actData(k), exp_d[k]);
      if (actValid(k) === 1'b1) last_seen[k] = actData(k);
    end
  end

  task automatic checkLast(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2);
    checkOutput({tag, "_rf"}, last_seen[0], e0);
    checkOutput({tag, "_wf"}, last_seen[1], e1);
    checkOutput({tag, "_nc"}, last_seen[2], e2);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    checkLast("por_dummy_skip", dout_rf, dout_wf, dout_nc);
    checkOutput("reset_valid", {29'h0, dv_rf, dv_wf, dv_nc}, 32'h0);
    checkOutput("reset_dout_rf", dout_rf, 32'h0);
    checkOutput("reset_dout_nc", dout_nc, 32'h0);
    idle(2);

    // First edge after release carries a full write; read-first returns the zero-filled word.
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; we = 1'b1; be = 4'hF; addr = 4'd5; din = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    checkOutput("rf_first_write_valid", {31'h0, dv_rf}, 32'h1);
    checkOutput("rf_first_write_old", dout_rf, 32'h0);

    applyStimulus(1'b1, 1'b0, 4'h0, 4'd5, 32'h0);
    checkOutput("rf_read5_valid", {31'h0, dv_rf}, 32'h1);
    checkOutput("rf_read5_data", dout_rf, 32'hDEADBEEF);
    idle(1);
    checkOutput("rf_hold_valid", {31'h0, dv_rf}, 32'h0);
    checkOutput("rf_hold_data", dout_rf, 32'hDEADBEEF);

    applyStimulus(1'b1, 1'b1, 4'b0101, 4'd5, 32'h11223344);
    applyStimulus(1'b1, 1'b0, 4'h0, 4'd5, 32'h0);
    idle(5);
    checkLast("partial", 32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44);

    applyStimulus(1'b1, 1'b1, 4'hF, 4'd2, 32'hAAAAAAAA);
    idle(1);
    applyStimulus(1'b1, 1'b1, 4'b0011, 4'd2, 32'h55555555);
    idle(5);
    checkLast("rdw", 32'hAAAAAAAA, 32'hAAAA5555, 32'hDE22BE44);
    applyStimulus(1'b1, 1'b0, 4'h0, 4'd2, 32'h0);
    idle(5);
    checkLast("rdw_reread", 32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555);

    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 4'hF, 4'(i), 32'(i));
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 4'h0, 4'(i), 32'h0);
      if (i >= 2) begin
        checkOutput("wf_burst_valid", {31'h0, dv_wf}, 32'h1);
        checkOutput("wf_burst_data", dout_wf, 32'(i - 2));
      end
    end
    idle(1);
    checkOutput("wf_burst_data6", dout_wf, 32'd6);
    idle(1);
    checkOutput("wf_burst_data7", dout_wf, 32'd7);
    idle(1);
    checkOutput("wf_burst_end_valid", {31'h0, dv_wf}, 32'h0);
    checkOutput("wf_burst_end_hold", dout_wf, 32'd7);

    // Reset between edges with reads in flight; the write issued during reset must be ignored.
    applyStimulus(1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 4'd4, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", {29'h0, dv_rf, dv_wf, dv_nc}, 32'h0);
    checkOutput("async_reset_dout_nc", dout_nc, 32'h0);
    checkOutput("async_reset_dout_wf", dout_wf, 32'h0);
    applyStimulus(1'b1, 1'b1, 4'hF, 4'd3, 32'hFFFFFFFF);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0;
    idle(5);
    applyStimulus(1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
    idle(5);
    checkLast("post_reset_reread", 32'd3, 32'd3, 32'd3);

    applyStimulus(1'b1, 1'b1, 4'hF, 4'd13, 32'h12345678);
    applyStimulus(1'b1, 1'b0, 4'h0, 4'd13, 32'h0);
    idle(5);
    checkLast("addr13", 32'h12345678, 32'h12345678, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 4'd1, 32'h0);
    idle(5);
    checkLast("addr1_intact", 32'd1, 32'd1, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
